sync_fifo_pkt: RTL
==================

Name: sync_fifo_pkt

Overview:
Single-clock FIFO that generalises the dual-clock FIFO family for use inside one clock domain of the TSN switch datapath. It is parametrised in width and depth, and offers both standard and first-word-fall-through (FWFT) read modes. It adds programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags. An optional packet mode lets the writer commit or discard a whole frame, so readers never see a partial frame.

Parameters:
DATA_WIDTH, 8, word width in bits
FIFO_DEPTH, 16, number of entries; power of two, >=4
DATA_FLOAT_OUT, 0, 0 = standard read (1-cycle latency); 1 = FWFT
PKT_MODE, 0, 0 = every write auto-committed; 1 = writes visible only after WR_COMMIT
AF_TH, 2, ALMOST_FULL asserts when free slots <= AF_TH
AE_TH, 2, ALMOST_EMPTY asserts when RD_CNT <= AE_TH
(PTR_WIDTH = log2(FIFO_DEPTH), derived, not overridable)

Ports:
CLK  in  1  single clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
WR_EN  in  1  write request
WR_DATA  in  DATA_WIDTH  write word
WR_COMMIT  in  1  publish all pending writes, including this cycle's (PKT_MODE=1 only)
WR_DISCARD  in  1  drop all pending writes, including this cycle's (PKT_MODE=1 only)
WR_FULL  out  1  no free slot
WR_CNT  out  PTR_WIDTH+1  occupied slots, committed plus pending
ALMOST_FULL  out  1  threshold flag
RD_EN  in  1  read request
RD_DATA  out  DATA_WIDTH  read word
RD_EMPTY  out  1  no committed word available
RD_CNT  out  PTR_WIDTH+1  committed words readable; FWFT count includes the output register
ALMOST_EMPTY  out  1  threshold flag
OVERFLOW  out  1  sticky: WR_EN while WR_FULL
UNDERFLOW  out  1  sticky: RD_EN while RD_EMPTY
CLR_ERR  in  1  synchronous clear of OVERFLOW/UNDERFLOW

Behaviour:
- Reset (RST_N low, asynchronous):
  - pointers wr_ptr, cmt_ptr and rd_ptr go to 0; RD_DATA goes to 0.
  - RD_EMPTY=1, WR_FULL=0, WR_CNT=RD_CNT=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=UNDERFLOW=0.
  - Memory contents are not reset.
  - Reset mid-frame discards everything, committed or not.
- Pointers are PTR_WIDTH+1 bits and wrap modulo 2*FIFO_DEPTH. Counts are pointer differences modulo the same.
- Write:
  - Accepted when WR_EN=1 and WR_FULL=0; memory is written at wr_ptr, then wr_ptr increments.
  - WR_EN=1 with WR_FULL=1: word dropped, pointers unchanged, OVERFLOW set.
  - WR_FULL = (wr_ptr - rd_ptr == FIFO_DEPTH); WR_CNT = wr_ptr - rd_ptr. Both are registered, valid the cycle after the edge.
- Commit:
  - PKT_MODE=0: cmt_ptr tracks wr_ptr on every accepted write; WR_COMMIT and WR_DISCARD are ignored.
  - PKT_MODE=1, WR_COMMIT: cmt_ptr <= wr_ptr plus this cycle's accepted write.
  - PKT_MODE=1, WR_DISCARD: wr_ptr <= cmt_ptr and this cycle's write is dropped.
  - WR_COMMIT and WR_DISCARD in the same cycle: discard wins.
  - A frame larger than the free space fills the FIFO, sets OVERFLOW and stalls. The writer must then issue WR_DISCARD; the block does not recover on its own.
- Standard read (DATA_FLOAT_OUT=0):
  - Accepted when RD_EN=1 and RD_EMPTY=0; RD_DATA <= mem[rd_ptr] at that edge, then rd_ptr increments.
  - RD_DATA holds its value until the next accepted read.
  - RD_EMPTY = (cmt_ptr == rd_ptr). A word committed at edge N is readable from edge N+1.
- FWFT read (DATA_FLOAT_OUT=1):
  - A one-entry output register plus a valid bit; RD_EMPTY = !valid.
  - Load: if the register is empty (or being consumed) and memory holds a committed word, load it at the next edge. A word committed at edge N appears at RD_DATA with RD_EMPTY=0 after edge N+1.
  - RD_EN with RD_EMPTY=0 consumes the word. The next word, if available, replaces it at the same edge with no bubble; otherwise RD_EMPTY goes to 1.
  - RD_DATA is stable while RD_EMPTY=0 and RD_EN=0.
- RD_EN=1 with RD_EMPTY=1: no state change; UNDERFLOW set.
- Simultaneous read and write at full: the write is rejected (WR_FULL is registered) while the read proceeds. At empty, the read is rejected while the write proceeds.
- ALMOST_FULL = (FIFO_DEPTH - WR_CNT <= AF_TH); ALMOST_EMPTY = (RD_CNT <= AE_TH). Both are registered alongside the counts.
- CLR_ERR clears the sticky flags. If a new error occurs in the same cycle, set wins.

Test Plan:
- Std mode, PKT_MODE=0:
  - Write 0xAA,0x55,0xCC,0x33 -> WR_CNT=4, RD_EMPTY=0.
  - Read 4 -> RD_DATA=AA,55,CC,33, each one cycle after its RD_EN edge.
  - RD_EMPTY=1 afterwards, RD_CNT=0.
- Fill and overflow:
  - Write 0..15 -> WR_FULL=1, ALMOST_FULL asserted from WR_CNT=14.
  - Write 0xFF -> OVERFLOW=1, WR_CNT stays 16.
  - Read 16 -> data 0..15 in order, no 0xFF.
  - One extra RD_EN -> UNDERFLOW=1; CLR_ERR -> both flags 0.
- FWFT:
  - Write 0xF0 -> RD_DATA=0xF0 with RD_EMPTY=0 two edges later, without RD_EN.
  - Write 0x0F -> RD_DATA stays 0xF0.
  - One RD_EN -> RD_DATA=0x0F on the next cycle.
  - Second RD_EN -> RD_EMPTY=1.
- Packet mode, commit:
  - Write 3 words -> RD_EMPTY stays 1, WR_CNT=3, RD_CNT=0.
  - WR_COMMIT with a 4th write -> RD_CNT=4 the next cycle.
- Packet mode, discard:
  - Commit frame A (2 words), then write 5 words of frame B.
  - WR_DISCARD -> WR_CNT=2; reads return only frame A.
  - Assert commit and discard together on the next frame -> nothing published.
- Wrap and streaming:
  - 40 words with WR_EN and RD_EN both held high, depth 16 -> sequence intact across pointer wrap, no flag errors.
  - RST_N pulse mid-stream -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/sync_fifo_pkt.sv
// sync_fifo_pkt: single-clock FIFO with standard/FWFT read, threshold flags, sticky errors and packet commit/discard
//
// Ports:
//   CLK, RST_N          clock (rising edge) and asynchronous active-low reset
//   WR_EN, WR_DATA      write request and word
//   WR_COMMIT           publish pending writes including this cycle's (packet mode)
//   WR_DISCARD          drop pending writes including this cycle's (packet mode), wins over commit
//   WR_FULL, WR_CNT     no free slot / occupied slots (committed plus pending)
//   ALMOST_FULL         free slots <= AF_TH
//   RD_EN, RD_DATA      read request and word
//   RD_EMPTY, RD_CNT    no committed word / committed words readable (FWFT includes output register)
//   ALMOST_EMPTY        RD_CNT <= AE_TH
//   OVERFLOW, UNDERFLOW sticky error flags, CLR_ERR clears them (a new error in the same cycle wins)
module sync_fifo_pkt #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int DATA_FLOAT_OUT = 0,
    parameter int PKT_MODE       = 0,
    parameter int AF_TH          = 2,
    parameter int AE_TH          = 2
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            WR_EN,
    input  logic [DATA_WIDTH-1:0]           WR_DATA,
    input  logic                            WR_COMMIT,
    input  logic                            WR_DISCARD,
    output logic                            WR_FULL,
    output logic [$clog2(FIFO_DEPTH):0]     WR_CNT,
    output logic                            ALMOST_FULL,
    input  logic                            RD_EN,
    output logic [DATA_WIDTH-1:0]           RD_DATA,
    output logic                            RD_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]     RD_CNT,
    output logic                            ALMOST_EMPTY,
    output logic                            OVERFLOW,
    output logic                            UNDERFLOW,
    input  logic                            CLR_ERR
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam bit FWFT = DATA_FLOAT_OUT != 0;
    localparam bit PKT  = PKT_MODE != 0;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW:0]           wr_ptr_q, cmt_ptr_q, rd_ptr_q, wr_cnt_q, rd_cnt_q;
    logic [PW:0]           wr_ptr_d, cmt_ptr_d, rd_ptr_d, wr_cnt_d, rd_cnt_d, wr_inc;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  wr_full_q, rd_empty_q, af_q, ae_q, ovf_q, unf_q;
    logic                  rd_empty_d, disc, cmt, wr_acc, mem_avail, load, valid_d;

    always_comb begin
        disc      = PKT && WR_DISCARD;
        cmt       = PKT && WR_COMMIT && !WR_DISCARD;
        wr_acc    = WR_EN && !wr_full_q && !disc;
        wr_inc    = wr_ptr_q + (PW+1)'(wr_acc);
        wr_ptr_d  = disc ? cmt_ptr_q : wr_inc;
        cmt_ptr_d = (!PKT || cmt) ? wr_inc : cmt_ptr_q;
        mem_avail = cmt_ptr_q != rd_ptr_q;
        // FWFT refills the output register whenever it is empty or being consumed;
        // in FWFT mode rd_empty_q is the inverse of the output-register valid bit
        load       = mem_avail && (FWFT ? (rd_empty_q || RD_EN) : RD_EN);
        rd_ptr_d   = rd_ptr_q + (PW+1)'(load);
        valid_d    = load || (!rd_empty_q && !RD_EN);
        rd_empty_d = FWFT ? !valid_d : (cmt_ptr_d == rd_ptr_d);
        wr_cnt_d   = wr_ptr_d - rd_ptr_d;
        rd_cnt_d   = cmt_ptr_d - rd_ptr_d + (PW+1)'(FWFT && !rd_empty_d);
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) mem[wr_ptr_q[PW-1:0]] <= WR_DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            wr_full_q  <= 1'b0;
            rd_empty_q <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            if (load) rd_data_q <= mem[rd_ptr_q[PW-1:0]];
            wr_full_q  <= wr_cnt_d == (PW+1)'(FIFO_DEPTH);
            rd_empty_q <= rd_empty_d;
            af_q       <= (FIFO_DEPTH - int'(wr_cnt_d)) <= AF_TH;
            ae_q       <= int'(rd_cnt_d) <= AE_TH;
            ovf_q      <= (WR_EN && wr_full_q) || (ovf_q && !CLR_ERR);
            unf_q      <= (RD_EN && rd_empty_q) || (unf_q && !CLR_ERR);
        end
    end

    assign WR_FULL      = wr_full_q;
    assign WR_CNT       = wr_cnt_q;
    assign ALMOST_FULL  = af_q;
    assign RD_DATA      = rd_data_q;
    assign RD_EMPTY     = rd_empty_q;
    assign RD_CNT       = rd_cnt_q;
    assign ALMOST_EMPTY = ae_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;
endmodule
